// File: rtl/axis_table_bridge.sv
// -----------------------------------------------------------------------------
// axis_table_bridge
//
// Parametrised AXI-Stream front end for the hash table core.
// A command beat {op[1:0], key, data} is captured in a one-entry command
// register and presented to the table one cycle later. Table responses are
// written into a small response FIFO and leave as RESP_WIDTH-bit result beats
// {flags[3:0], zeros, read_data}.
//
// Flow control is credit based. A request is only issued while the FIFO has a
// slot for every response still in flight, so the table response path never
// stalls and tbl_ready_o is simply "out of reset".
//
// Op 11 is a local status command. It waits until the table is idle
// (nothing outstanding) and then writes one result directly into the FIFO.
// This keeps results in command order.
//
// Handshakes: a beat transfers on a rising clk edge where valid & ready are
// both high. A source holds valid and its payload steady until that edge, and
// valid never depends combinationally on ready from the same interface.
//
// Optional feature (macro BRIDGE_STAT_COUNTERS_EN):
//   defined   - two saturating DATA_WIDTH-bit counters are present. The first
//               counts table request handshakes. The second counts table
//               responses that carry any flag bit. An op 11 result returns
//               {3'b000, second!=0, zeros, first}.
//   undefined - an op 11 result is all zeros, so it acts as an ordering
//               fence/ping.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   s_data_i          command beat: [MSB-:2]=op, then key, data in LSBs
//   s_valid_i/s_ready_o          command handshake
//   m_data_o          result beat
//   m_valid_o/m_ready_i          result handshake
//   tbl_op_o/key_o/data_o        table request (00 delete, 01 write, 10 read)
//   tbl_valid_o/tbl_ready_i      table request handshake
//   tbl_valid_i/tbl_ready_o      table response handshake
//   tbl_read_data_i   table read data
//   tbl_flags_i       {key_already_present, no_element_found,
//                      no_write_space, no_deletion_target}
// -----------------------------------------------------------------------------
module axis_table_bridge #(
    parameter int KEY_WIDTH  = 5,
    parameter int DATA_WIDTH = 25,
    parameter int RESP_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [2+KEY_WIDTH+DATA_WIDTH-1:0] s_data_i,
    input  logic                              s_valid_i,
    output logic                              s_ready_o,
    output logic [RESP_WIDTH-1:0]             m_data_o,
    output logic                              m_valid_o,
    input  logic                              m_ready_i,
    output logic [1:0]                        tbl_op_o,
    output logic [KEY_WIDTH-1:0]              tbl_key_o,
    output logic [DATA_WIDTH-1:0]             tbl_data_o,
    output logic                              tbl_valid_o,
    input  logic                              tbl_ready_i,
    input  logic                              tbl_valid_i,
    output logic                              tbl_ready_o,
    input  logic [DATA_WIDTH-1:0]             tbl_read_data_i,
    input  logic [3:0]                        tbl_flags_i
);

    localparam int CMD_W = 2 + KEY_WIDTH + DATA_WIDTH;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam logic [1:0] OP_STATUS = 2'b11;

    // Goes high on the first clock edge after reset release; gates both
    // ready outputs so nothing is accepted while reset is active.
    logic                  r_active;

    logic                  r_cmd_valid;
    logic [1:0]            r_cmd_op;
    logic [KEY_WIDTH-1:0]  r_cmd_key;
    logic [DATA_WIDTH-1:0] r_cmd_data;

    logic [CW-1:0]         r_out;
    logic [CW-1:0]         r_count;
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [RESP_WIDTH-1:0] r_mem [FIFO_DEPTH];

`ifdef BRIDGE_STAT_COUNTERS_EN
    logic [DATA_WIDTH-1:0] r_stat_req;
    logic [DATA_WIDTH-1:0] r_stat_flag;
`endif

    logic [CW-1:0]         w_free;
    logic                  w_is_status;
    logic                  w_req_valid;
    logic                  w_req_fire;
    logic                  w_rsp_fire;
    logic                  w_fifo_full;
    logic                  w_stat_fire;
    logic                  w_drain;
    logic                  w_s_ready;
    logic                  w_s_fire;
    logic                  w_push;
    logic                  w_pop;
    logic [RESP_WIDTH-1:0] w_push_word;

    // Slots not yet claimed by stored results or in-flight responses.
    // count + outstanding never exceeds FIFO_DEPTH, so this cannot wrap.
    assign w_free      = CW'(FIFO_DEPTH) - r_count - r_out;
    assign w_is_status = (r_cmd_op == OP_STATUS);

    // free only shrinks through our own request handshake (a response moves
    // one credit from outstanding into the FIFO), so a raised tbl_valid_o
    // stays high until it is taken.
    assign w_req_valid = r_cmd_valid & ~w_is_status & (w_free != '0);
    assign w_req_fire  = w_req_valid & tbl_ready_i;
    assign w_rsp_fire  = tbl_valid_i & r_active;
    assign w_fifo_full = (r_count == CW'(FIFO_DEPTH));

    // Status completes only with the table idle, so it never races a
    // response for the FIFO write port; the rsp term is a safety net.
    assign w_stat_fire = r_cmd_valid & w_is_status & (r_out == '0)
                       & ~w_fifo_full & ~w_rsp_fire;
    assign w_drain     = w_req_fire | w_stat_fire;
    assign w_s_ready   = r_active & (~r_cmd_valid | w_drain);
    assign w_s_fire    = s_valid_i & w_s_ready;

    assign w_push = w_rsp_fire | w_stat_fire;
    assign w_pop  = (r_count != '0) & m_ready_i;

    always_comb begin
        w_push_word = '0;
        if (w_rsp_fire) begin
            w_push_word[RESP_WIDTH-1 -: 4]  = tbl_flags_i;
            w_push_word[DATA_WIDTH-1:0]     = tbl_read_data_i;
        end
`ifdef BRIDGE_STAT_COUNTERS_EN
        else begin
            w_push_word[RESP_WIDTH-1 -: 4]  = {3'b000, (r_stat_flag != '0)};
            w_push_word[DATA_WIDTH-1:0]     = r_stat_req;
        end
`endif
    end

    assign s_ready_o   = w_s_ready;
    assign tbl_valid_o = w_req_valid;
    assign tbl_ready_o = r_active;
    assign tbl_op_o    = r_cmd_op;
    assign tbl_key_o   = r_cmd_key;
    assign tbl_data_o  = r_cmd_data;
    assign m_valid_o   = (r_count != '0);
    assign m_data_o    = r_mem[r_rptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_active    <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= '0;
            r_cmd_key   <= '0;
            r_cmd_data  <= '0;
        end else begin
            r_active <= 1'b1;
            if (w_s_fire) begin
                r_cmd_valid <= 1'b1;
                r_cmd_op    <= s_data_i[CMD_W-1 -: 2];
                r_cmd_key   <= s_data_i[DATA_WIDTH +: KEY_WIDTH];
                r_cmd_data  <= s_data_i[DATA_WIDTH-1:0];
            end else if (w_drain) begin
                r_cmd_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out <= '0;
        end else begin
            case ({w_req_fire, w_rsp_fire})
                2'b10:   r_out <= r_out + CW'(1);
                2'b01:   r_out <= r_out - CW'(1);
                default: r_out <= r_out;
            endcase
        end
    end

    // Push and pop may coincide at any fill level; a push into an empty FIFO
    // becomes visible on m_valid_o one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_push_word;
                r_wptr        <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

`ifdef BRIDGE_STAT_COUNTERS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_req  <= '0;
            r_stat_flag <= '0;
        end else begin
            if (w_req_fire && (r_stat_req != '1)) begin
                r_stat_req <= r_stat_req + DATA_WIDTH'(1);
            end
            if (w_rsp_fire && (tbl_flags_i != 4'b0000) && (r_stat_flag != '1)) begin
                r_stat_flag <= r_stat_flag + DATA_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: doc/axis_table_bridge.md
Name: axis_table_bridge

Overview:
- Parametrised AXI-Stream front end for the hash table core. It replaces the fixed 32-bit wrapper.
- Decodes a command beat {op[1:0], key, data} into table request signals.
- Buffers table responses in an internal response FIFO and packs them into a RESP_WIDTH-bit result beat.
- Uses credit-based flow control, so the table response path is never stalled. Multiple requests may be outstanding.

Parameters:
KEY_WIDTH, 5, key field width
DATA_WIDTH, 25, data field width
RESP_WIDTH, 32, result beat width; must be >= DATA_WIDTH+4
FIFO_DEPTH, 4, response FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
s_data_i  in  2+KEY_WIDTH+DATA_WIDTH  command beat: [MSB-:2]=op, then key, data in LSBs
s_valid_i  in  1  command valid
s_ready_o  out  1  command ready
m_data_o  out  RESP_WIDTH  result beat
m_valid_o  out  1  result valid
m_ready_i  in  1  result ready
tbl_op_o  out  2  table op: 00 delete, 01 write, 10 read
tbl_key_o  out  KEY_WIDTH  table key
tbl_data_o  out  DATA_WIDTH  table write data
tbl_valid_o  out  1  table request valid
tbl_ready_i  in  1  table request ready
tbl_valid_i  in  1  table response valid
tbl_ready_o  out  1  table response ready
tbl_read_data_i  in  DATA_WIDTH  table read data
tbl_flags_i  in  4  {key_already_present, no_element_found, no_write_space, no_deletion_target}

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - outputs: s_ready_o=0, m_valid_o=0, tbl_valid_o=0, m_data_o=0, tbl_op_o/key/data=0;
  - state: FIFO pointers, outstanding counter and command register.
- First cycle after reset release: s_ready_o=1, tbl_ready_o=1.
- Command register: one-entry slice.
  - s_ready_o = register empty, or register being drained this cycle.
  - s_valid_i & s_ready_o loads the register.
  - Data appears on tbl_* one cycle later: 1-cycle request latency.
- Credit:
  - free = FIFO_DEPTH − fifo_count − outstanding.
  - A table op (00/01/10) in the register asserts tbl_valid_o only while free > 0.
  - tbl_valid_o must not drop once asserted until tbl_valid_o & tbl_ready_i.
  - outstanding +1 on request handshake.
  - outstanding −1 on tbl_valid_i & tbl_ready_o.
  - Both in the same cycle: no change.
  - outstanding is ceil(log2(FIFO_DEPTH+1)) bits.
- tbl_ready_o = 1 whenever out of reset. By construction a table response never finds the FIFO full.
- Table response handling:
  - written into the FIFO on the cycle of the response handshake;
  - m_valid_o rises the next cycle at the earliest (1-cycle response latency).
- Result packing:
  - m_data_o[RESP_WIDTH-1 -: 4] = tbl_flags_i;
  - m_data_o[DATA_WIDTH-1:0] = tbl_read_data_i;
  - all bits between are 0.
- Local op 11 (status):
  - never sent to the table;
  - waits in the command register until outstanding==0 and the FIFO is not full;
  - then writes one local result directly into the FIFO and frees the register.
  - Results stay in command order.
- FIFO read: m_valid_o = FIFO not empty; pop on m_valid_o & m_ready_i.
- FIFO push and pop in the same cycle are allowed at any fill level, including full and empty.
  - A push into an empty FIFO is not visible until the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- m_data_o and m_valid_o are stable while m_valid_o & !m_ready_i.
- Reset mid-operation: all in-flight commands and results are discarded.
  - The table core shares the reset, so no stale response is expected.

Optional Feature:
- Macro: BRIDGE_STAT_COUNTERS_EN.
- Defined:
  - a DATA_WIDTH-bit saturating counter counts accepted table-op commands (request handshakes);
  - a second saturating counter counts results carrying any flag bit set;
  - an op 11 result returns the first counter in data[DATA_WIDTH-1:0];
  - flag field = {3'b000, second counter != 0};
  - both counters clear on reset only.
- Undefined: op 11 returns an all-zero result beat (acts as an ordering fence/ping). No counter logic is present.

Test Plan:
- Reset, then one write op=01 key=5'h03 data=25'h0000AA, table responds flags=0 -> tbl_valid_o one cycle after s handshake; m_data_o=32'h0 after response, m_valid_o=1 one cycle after tbl response.
- Read op=10 key=5'h03, table returns data=25'h0000AA flags=0 -> m_data_o=32'h000000AA.
- Read of missing key, table flags=4'b0100 -> m_data_o=32'h40000000.
- m_ready_i=0, FIFO_DEPTH=4, stream 6 reads with 0-cycle table latency -> exactly 4 table handshakes, tbl_valid_o held low; then m_ready_i=1 -> remaining 2 issued, 6 results in order.
- Status op=11 behind 3 outstanding reads -> op 11 result is the 4th beat. With BRIDGE_STAT_COUNTERS_EN its data=3; without it m_data_o=0.
- Assert reset low mid-burst with 2 FIFO entries and 1 outstanding -> m_valid_o=0 and tbl_valid_o=0 immediately; first command after release is treated as first ever.
